br_predictor: RTL and testbench

- Dual-slot branch predictor: a direct-mapped BTB with 2-bit saturating counters per entry.
- Front end: gives the taken flag and predicted PC for the two instructions of a fetch packet (PC and PC+4), one cycle after the fetch PC is presented.
- Back end: trained by the EX-stage branch unit through its EX_pc_of_br / EX_pd_type / EX_br_target / EX_br_jump outputs.
- Its predictions travel down the pipe and become EX_br_pd_a/b and EX_pc_pd_a/b at EX.

---
 rtl/br_predictor.sv | 188 ++++++++++++++++++
 tb/tb_br_predictor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_predictor.sv
// rtl/br_predictor.sv - dual-slot direct-mapped BTB branch predictor with 2-bit counters
//
// Purpose: predicts taken/next-PC for the two instructions of a fetch packet
// (slot a = IF_pc, slot b = IF_pc+4) one cycle after the fetch PC is presented,
// and is trained by the EX-stage branch unit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IF_pc, IF_valid, IF_stall fetch packet PC, valid, hold outputs
//   PD_br_pd_a/b             slot taken predictions (registered)
//   PD_pc_pd_a/b             slot predicted next PCs (registered)
//   PD_pd_type_a/b           slot BTB types, 00 on miss (registered)
//   PD_valid                 outputs belong to a valid fetch
//   EX_pc_of_br, EX_pd_type, EX_br_target, EX_br_jump   training inputs
//   stat_upd_cnt, stat_miss_cnt   statistics (only with BP_STAT_EN)
//
// Optional feature macro: BP_STAT_EN adds the update/miss statistics counters.

module br_predictor #(
    parameter int         INDEX_W  = 6,
    parameter int         TAG_W    = 10,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_pc,
    input  logic        IF_valid,
    input  logic        IF_stall,
    output logic        PD_br_pd_a,
    output logic        PD_br_pd_b,
    output logic [31:0] PD_pc_pd_a,
    output logic [31:0] PD_pc_pd_b,
    output logic [1:0]  PD_pd_type_a,
    output logic [1:0]  PD_pd_type_b,
    output logic        PD_valid,
    input  logic [31:0] EX_pc_of_br,
    input  logic [1:0]  EX_pd_type,
    input  logic [31:0] EX_br_target,
    input  logic        EX_br_jump
`ifdef BP_STAT_EN
    ,
    output logic [31:0] stat_upd_cnt,
    output logic [31:0] stat_miss_cnt
`endif
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int TAG_LO = INDEX_W + 2;
    localparam int TAG_HI = INDEX_W + TAG_W + 1;

    // BTB storage: valid bits are resettable, the payload arrays are not.
    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [1:0]       r_type   [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];

    // ---------------- read ports ----------------
    logic [31:0]        w_pc_b;
    logic [INDEX_W-1:0] w_idx_a, w_idx_b;
    logic [TAG_W-1:0]   w_tag_a, w_tag_b;
    logic               w_hit_a, w_hit_b;
    logic               w_taken_a, w_taken_b;
    logic [31:0]        w_npc_a, w_npc_b;
    logic [1:0]         w_type_a, w_type_b;

    assign w_pc_b  = IF_pc + 32'd4;
    assign w_idx_a = IF_pc[INDEX_W+1:2];
    assign w_idx_b = w_pc_b[INDEX_W+1:2];
    assign w_tag_a = IF_pc[TAG_HI:TAG_LO];
    assign w_tag_b = w_pc_b[TAG_HI:TAG_LO];

    assign w_hit_a   = r_valid[w_idx_a] && (r_tag[w_idx_a] == w_tag_a);
    assign w_hit_b   = r_valid[w_idx_b] && (r_tag[w_idx_b] == w_tag_b);
    // Unconditional types always predict taken; conditionals follow ctr MSB.
    assign w_taken_a = w_hit_a && ((r_type[w_idx_a] != 2'b01) || r_ctr[w_idx_a][1]);
    assign w_taken_b = w_hit_b && ((r_type[w_idx_b] != 2'b01) || r_ctr[w_idx_b][1]);

    assign w_npc_a  = w_taken_a ? r_target[w_idx_a] : w_pc_b;
    assign w_type_a = w_hit_a ? r_type[w_idx_a] : 2'b00;

    // A taken slot a redirects the packet, so slot b is squashed.
    assign w_npc_b  = (w_taken_b && !w_taken_a) ? r_target[w_idx_b] : (IF_pc + 32'd8);
    assign w_type_b = (w_hit_b && !w_taken_a) ? r_type[w_idx_b] : 2'b00;

    // ---------------- write port ----------------
    logic [INDEX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_ex_hit;
    logic               w_upd;
    logic [1:0]         w_ctr_old;
    logic [1:0]         w_ctr_next;

    assign w_ex_idx  = EX_pc_of_br[INDEX_W+1:2];
    assign w_ex_tag  = EX_pc_of_br[TAG_HI:TAG_LO];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd     = (EX_pd_type != 2'b00);
    assign w_ctr_old = r_ctr[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_old;
        if (EX_br_jump && (w_ctr_old != 2'b11)) begin
            w_ctr_next = w_ctr_old + 2'b01;
        end else if (!EX_br_jump && (w_ctr_old != 2'b00)) begin
            w_ctr_next = w_ctr_old - 2'b01;
        end
    end

    // Payload arrays: written on a hit, or on an allocating (taken) miss.
    always_ff @(posedge clk) begin
        if (!rst && w_upd && (w_ex_hit || EX_br_jump)) begin
            r_target[w_ex_idx] <= EX_br_target;
            r_type[w_ex_idx]   <= EX_pd_type;
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= (EX_pd_type == 2'b01) ? w_ctr_next : 2'b11;
            end else begin
                r_tag[w_ex_idx] <= w_ex_tag;
                r_ctr[w_ex_idx] <= (EX_pd_type == 2'b01) ? CTR_INIT : 2'b11;
            end
        end
    end

    // Valid bits and registered prediction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            PD_valid     <= 1'b0;
            PD_br_pd_a   <= 1'b0;
            PD_br_pd_b   <= 1'b0;
            PD_pd_type_a <= 2'b00;
            PD_pd_type_b <= 2'b00;
            PD_pc_pd_a   <= 32'd0;
            PD_pc_pd_b   <= 32'd0;
        end else begin
            if (w_upd && !w_ex_hit && EX_br_jump) begin
                r_valid[w_ex_idx] <= 1'b1;
            end
            if (!IF_stall) begin
                if (IF_valid) begin
                    PD_valid     <= 1'b1;
                    PD_br_pd_a   <= w_taken_a;
                    PD_br_pd_b   <= w_taken_b && !w_taken_a;
                    PD_pd_type_a <= w_type_a;
                    PD_pd_type_b <= w_type_b;
                    PD_pc_pd_a   <= w_npc_a;
                    PD_pc_pd_b   <= w_npc_b;
                end else begin
                    // Next-PC fields are meaningless without a valid fetch; they hold.
                    PD_valid     <= 1'b0;
                    PD_br_pd_a   <= 1'b0;
                    PD_br_pd_b   <= 1'b0;
                    PD_pd_type_a <= 2'b00;
                    PD_pd_type_b <= 2'b00;
                end
            end
        end
    end

`ifdef BP_STAT_EN
    // A correct prediction needs a hit, the right direction and, if taken,
    // the right target.
    logic w_ex_pred_taken;
    logic w_ex_correct;

    assign w_ex_pred_taken = (r_type[w_ex_idx] != 2'b01) || w_ctr_old[1];
    assign w_ex_correct    = w_ex_hit && (w_ex_pred_taken == EX_br_jump) &&
                             (!EX_br_jump || (r_target[w_ex_idx] == EX_br_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_cnt  <= 32'd0;
            stat_miss_cnt <= 32'd0;
        end else if (w_upd) begin
            stat_upd_cnt <= stat_upd_cnt + 32'd1;
            if (!w_ex_correct) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

    // PC bits outside the index/tag fields do not take part in lookup.
    logic w_unused_bits;
    assign w_unused_bits = ^{IF_pc[1:0], IF_pc[31:TAG_HI+1],
                             w_pc_b[1:0], w_pc_b[31:TAG_HI+1],
                             EX_pc_of_br[1:0], EX_pc_of_br[31:TAG_HI+1]};

endmodule

// File: tb/tb_br_predictor.sv
// tb/tb_br_predictor.sv - scoreboard bench for br_predictor with a reference model

module tb_br_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] IF_pc;
    logic        IF_valid;
    logic        IF_stall;
    logic        PD_br_pd_a;
    logic        PD_br_pd_b;
    logic [31:0] PD_pc_pd_a;
    logic [31:0] PD_pc_pd_b;
    logic [1:0]  PD_pd_type_a;
    logic [1:0]  PD_pd_type_b;
    logic        PD_valid;
    logic [31:0] EX_pc_of_br;
    logic [1:0]  EX_pd_type;
    logic [31:0] EX_br_target;
    logic        EX_br_jump;
`ifdef BP_STAT_EN
    logic [31:0] stat_upd_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    br_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .IF_pc        (IF_pc),
        .IF_valid     (IF_valid),
        .IF_stall     (IF_stall),
        .PD_br_pd_a   (PD_br_pd_a),
        .PD_br_pd_b   (PD_br_pd_b),
        .PD_pc_pd_a   (PD_pc_pd_a),
        .PD_pc_pd_b   (PD_pc_pd_b),
        .PD_pd_type_a (PD_pd_type_a),
        .PD_pd_type_b (PD_pd_type_b),
        .PD_valid     (PD_valid),
        .EX_pc_of_br  (EX_pc_of_br),
        .EX_pd_type   (EX_pd_type),
        .EX_br_target (EX_br_target),
        .EX_br_jump   (EX_br_jump)
`ifdef BP_STAT_EN
        ,
        .stat_upd_cnt (stat_upd_cnt),
        .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        int        tag;
        bit [31:0] tgt;
        int        typ;
        int        ctr;
    } entry_t;

    typedef struct {
        bit        valid;
        bit        br_a;
        bit        br_b;
        bit [31:0] pc_a;
        bit [31:0] pc_b;
        bit [1:0]  ty_a;
        bit [1:0]  ty_b;
        bit        chk_pc;
    } pred_t;

    entry_t btb [int];
    pred_t  exp_q [$];
    pred_t  last_exp;

    int tests;
    int failed;

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int tag_of(input bit [31:0] pc);
        return int'((pc / 256) % 1024);
    endfunction

    function automatic void lookup(input bit [31:0] pc, output bit hit, output bit taken,
                                   output bit [31:0] tgt, output int typ);
        entry_t e;
        hit = 0; taken = 0; tgt = 0; typ = 0;
        if (btb.exists(idx_of(pc))) begin
            e = btb[idx_of(pc)];
            hit = e.v && (e.tag == tag_of(pc));
        end
        if (hit) begin
            typ   = e.typ;
            tgt   = e.tgt;
            taken = (e.typ != 1) || (e.ctr >= 2);
        end
    endfunction

    function automatic pred_t predict(input bit [31:0] pc);
        pred_t p;
        bit hit_a, tk_a, hit_b, tk_b;
        bit [31:0] t_a, t_b;
        int ty_a, ty_b;
        lookup(pc, hit_a, tk_a, t_a, ty_a);
        lookup(pc + 4, hit_b, tk_b, t_b, ty_b);
        p.valid  = 1;
        p.chk_pc = 1;
        p.br_a   = tk_a;
        p.pc_a   = tk_a ? t_a : pc + 4;
        p.ty_a   = 2'(ty_a);
        if (tk_a) begin
            p.br_b = 0;
            p.ty_b = 0;
            p.pc_b = pc + 8;
        end else begin
            p.br_b = tk_b;
            p.ty_b = 2'(ty_b);
            p.pc_b = tk_b ? t_b : pc + 8;
        end
        return p;
    endfunction

    function automatic void train(input bit [31:0] pc, input int typ,
                                  input bit [31:0] tgt, input bit jump);
        bit hit, tk;
        bit [31:0] t;
        int ty;
        entry_t e;
        lookup(pc, hit, tk, t, ty);
        if (hit) begin
            e = btb[idx_of(pc)];
            if (typ == 1) e.ctr = jump ? ((e.ctr < 3) ? e.ctr + 1 : 3) : ((e.ctr > 0) ? e.ctr - 1 : 0);
            else          e.ctr = 3;
            e.tgt = tgt;
            e.typ = typ;
            btb[idx_of(pc)] = e;
        end else if (jump) begin
            e.v   = 1;
            e.tag = tag_of(pc);
            e.tgt = tgt;
            e.typ = typ;
            e.ctr = (typ == 1) ? 2 : 3;
            btb[idx_of(pc)] = e;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit [31:0] pc, input bit v, input bit st,
                        input bit [31:0] ex_pc, input bit [1:0] ex_t,
                        input bit [31:0] ex_tgt, input bit ex_j);
        pred_t e;
        rst          = r;
        IF_pc        = pc;
        IF_valid     = v;
        IF_stall     = st;
        EX_pc_of_br  = ex_pc;
        EX_pd_type   = ex_t;
        EX_br_target = ex_tgt;
        EX_br_jump   = ex_j;
        if (r) begin
            e = '{default: 0};
            e.chk_pc = 1;
            btb.delete();
        end else begin
            if (st) begin
                e = last_exp;
            end else if (!v) begin
                e = last_exp;
                e.valid = 0; e.br_a = 0; e.br_b = 0; e.ty_a = 0; e.ty_b = 0; e.chk_pc = 0;
            end else begin
                e = predict(pc);
            end
            if (ex_t != 2'b00) train(ex_pc, int'(ex_t), ex_tgt, ex_j);
        end
        @(posedge clk);
        exp_q.push_back(e);
        last_exp = e;
        #1;
    endtask

    task automatic fetch(input bit [31:0] pc);
        step(0, pc, 1, 0, 32'd0, 2'b00, 32'd0, 0);
    endtask

    task automatic upd(input bit [31:0] pc, input bit [1:0] t, input bit [31:0] tgt, input bit j);
        step(0, 32'd0, 0, 0, pc, t, tgt, j);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        pred_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pd_valid",  32'(PD_valid),     32'(e.valid));
            chk("br_pd_a",   32'(PD_br_pd_a),   32'(e.br_a));
            chk("br_pd_b",   32'(PD_br_pd_b),   32'(e.br_b));
            chk("pd_type_a", 32'(PD_pd_type_a), 32'(e.ty_a));
            chk("pd_type_b", 32'(PD_pd_type_b), 32'(e.ty_b));
            if (e.chk_pc) begin
                chk("pc_pd_a", PD_pc_pd_a, e.pc_a);
                chk("pc_pd_b", PD_pc_pd_b, e.pc_b);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit [31:0] rpc, epc;
        tests = 0;
        failed = 0;
        last_exp = '{default: 0};
        rst = 1; IF_pc = 0; IF_valid = 0; IF_stall = 0;
        EX_pc_of_br = 0; EX_pd_type = 0; EX_br_target = 0; EX_br_jump = 0;

        // reset, with an update presented during reset that must be discarded
        step(1, 32'd0, 0, 0, 32'h1C000004, 2'b10, 32'h1C000FF0, 1);
        step(1, 32'd0, 0, 0, 32'd0, 2'b00, 32'd0, 0);

        fetch(32'h1C000000);                                  // cold miss
        upd(32'h1C000004, 2'b01, 32'h1C000100, 1);            // allocate ctr=10
        fetch(32'h1C000000);                                  // slot b taken
        upd(32'h1C000004, 2'b01, 32'h1C000100, 0);            // 10 -> 01
        upd(32'h1C000004, 2'b01, 32'h1C000100, 0);            // 01 -> 00
        fetch(32'h1C000000);
        upd(32'h1C000004, 2'b01, 32'h1C000100, 0);            // saturate at 00
        upd(32'h1C000004, 2'b01, 32'h1C000100, 1);            // 00 -> 01, still not taken
        fetch(32'h1C000000);
        upd(32'h1C000000, 2'b10, 32'h1C000200, 1);            // direct allocate
        fetch(32'h1C000000);                                  // slot a taken, b squashed

        // same-cycle read/write to one index: old entry first, new entry next cycle
        step(0, 32'h1C000010, 1, 0, 32'h1C000010, 2'b11, 32'h1C000400, 1);
        fetch(32'h1C000010);

        // aliasing index with a different tag
        fetch(32'h1C000000 + (32'd1 << 8));

        // stall hold for 3 cycles while the BTB still trains
        fetch(32'h1C000000);
        step(0, 32'h1C000040, 1, 1, 32'h1C000000, 2'b10, 32'h1C000500, 1);
        step(0, 32'h1C000044, 0, 1, 32'd0, 2'b00, 32'd0, 0);
        step(0, 32'h1C000048, 1, 1, 32'd0, 2'b00, 32'd0, 0);
        fetch(32'h1C000000);                                  // sees stalled-cycle update
        step(0, 32'h1C000000, 1, 1, 32'd0, 2'b00, 32'd0, 0);
        step(1, 32'h1C000000, 1, 1, 32'd0, 2'b00, 32'd0, 0);  // reset wins over stall
        fetch(32'h1C000000);                                  // BTB empty again

        // randomized traffic over a small PC window so entries collide and hit
        for (int i = 0; i < 3000; i++) begin
            rpc = 32'h1C000000 + (32'($urandom_range(0, 63)) << 2) + (32'($urandom_range(0, 2)) << 8);
            epc = 32'h1C000000 + (32'($urandom_range(0, 63)) << 2) + (32'($urandom_range(0, 2)) << 8);
            step(($urandom_range(0, 499) == 0),
                 rpc,
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) == 0),
                 epc,
                 ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                 32'h1C000000 + (32'($urandom_range(0, 1023)) << 2),
                 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
